// File: rtl/dma_mem_slave_if.sv
// rtl/dma_mem_slave_if.sv - Avalon-MM style read/write port bundle between a DMA master and the memory slave
interface dma_mem_slave_if;
  logic [31:0] iAddress_Slave_Read;
  logic        iRead_Slave_Read;
  logic        oWait_Slave_Read;
  logic        oDataValid_Slave_Read;
  logic [31:0] oReadData_Slave_Read;
  logic [31:0] iAddress_Slave_Write;
  logic [31:0] iData_Slave_Write;
  logic        iWrite_Slave_Write;
  logic        oWait_Slave_Write;
  logic [15:0] oRd_Count;
  logic [15:0] oWr_Count;
  logic        oAddr_Err;

  modport slave (
    input  iAddress_Slave_Read, iRead_Slave_Read,
    input  iAddress_Slave_Write, iData_Slave_Write, iWrite_Slave_Write,
    output oWait_Slave_Read, oDataValid_Slave_Read, oReadData_Slave_Read,
    output oWait_Slave_Write, oRd_Count, oWr_Count, oAddr_Err
  );

  modport master (
    output iAddress_Slave_Read, iRead_Slave_Read,
    output iAddress_Slave_Write, iData_Slave_Write, iWrite_Slave_Write,
    input  oWait_Slave_Read, oDataValid_Slave_Read, oReadData_Slave_Read,
    input  oWait_Slave_Write, oRd_Count, oWr_Count, oAddr_Err
  );
endinterface

// File: rtl/dma_mem_slave.sv
// rtl/dma_mem_slave.sv - word-addressed RAM slave with fixed-latency pipelined reads and posted writes
// Optional deterministic wait-state injection is built when DMA_SLV_STALL_EN is defined.
module dma_mem_slave #(
  parameter int          ADDR_W       = 10,
  parameter int          RD_LAT       = 2,
  parameter int          STALL_PERIOD = 4,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input logic            iClk,
  input logic            iRst,
  dma_mem_slave_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DMA_SLV_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic [31:0]       r_mem [0:DEPTH-1];
  logic [31:0]       r_ram_q;
  logic [RD_LAT-1:0] r_vld;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;
  logic              r_addr_err;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_rd_oor;
  logic              w_wr_oor;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_wait_rd;
  logic              w_wait_wr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_rd_idx = bus.iAddress_Slave_Read[ADDR_W+1:2];
  assign w_wr_idx = bus.iAddress_Slave_Write[ADDR_W+1:2];
  assign w_rd_oor = |bus.iAddress_Slave_Read[31:ADDR_W+2];
  assign w_wr_oor = |bus.iAddress_Slave_Write[31:ADDR_W+2];
  assign w_rd_acc = bus.iRead_Slave_Read && !w_wait_rd;
  assign w_wr_acc = bus.iWrite_Slave_Write && !w_wait_wr;
  assign w_unused = &{1'b0, bus.iAddress_Slave_Read[1:0], bus.iAddress_Slave_Write[1:0]};

  // Read and write share one edge; the read samples r_mem before the write lands, giving old data.
  always_ff @(posedge iClk) begin
    if (w_wr_acc && !w_wr_oor) begin
      r_mem[w_wr_idx] <= bus.iData_Slave_Write;
    end
    if (iRst) begin
      r_ram_q <= '0;
    end else if (w_rd_acc) begin
      r_ram_q <= w_rd_oor ? ERR_DATA : r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Each data stage loads only behind a valid, so the last stage holds between returns.
  generate
    if (RD_LAT > 1) begin : g_dpipe
      logic [31:0] r_pd [1:RD_LAT-1];
      always_ff @(posedge iClk) begin
        if (iRst) begin
          for (int i = 1; i < RD_LAT; i++) begin
            r_pd[i] <= '0;
          end
        end else begin
          if (r_vld[0]) begin
            r_pd[1] <= r_ram_q;
          end
          for (int i = 2; i < RD_LAT; i++) begin
            if (r_vld[i-1]) begin
              r_pd[i] <= r_pd[i-1];
            end
          end
        end
      end
      assign w_rdata = r_pd[RD_LAT-1];
    end else begin : g_dnopipe
      assign w_rdata = r_ram_q;
    end
  endgenerate

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wr_acc) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if ((w_rd_acc && w_rd_oor) || (w_wr_acc && w_wr_oor)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  generate
    if (STALL_EN && STALL_PERIOD > 0) begin : g_stall
      localparam int CW = $clog2(STALL_PERIOD + 1);
      logic [CW-1:0] r_stall_cnt;
      logic          r_wait_rd;
      logic          r_wait_wr;
      always_ff @(posedge iClk) begin
        if (iRst) begin
          r_stall_cnt <= '0;
          r_wait_rd   <= 1'b0;
          r_wait_wr   <= 1'b0;
        end else begin
          r_stall_cnt <= (r_stall_cnt == CW'(STALL_PERIOD - 1)) ? '0 : r_stall_cnt + CW'(1);
          r_wait_rd   <= (r_stall_cnt == CW'(STALL_PERIOD - 1));
          r_wait_wr   <= (r_stall_cnt == '0);
        end
      end
      assign w_wait_rd = r_wait_rd;
      assign w_wait_wr = r_wait_wr;
    end else begin : g_no_stall
      assign w_wait_rd = 1'b0;
      assign w_wait_wr = 1'b0;
    end
  endgenerate

  assign bus.oWait_Slave_Read      = w_wait_rd;
  assign bus.oWait_Slave_Write     = w_wait_wr;
  assign bus.oDataValid_Slave_Read = r_vld[RD_LAT-1];
  assign bus.oReadData_Slave_Read  = w_rdata;
  assign bus.oRd_Count             = r_rd_cnt;
  assign bus.oWr_Count             = r_wr_cnt;
  assign bus.oAddr_Err             = r_addr_err;
endmodule
